toccata_volume_ramp: RTL and testbench

Multi-channel successor to the Toccata volume stage. Applies per-channel 6-bit logarithmic attenuation (about -1.5 dB/step, factor 27553/32768) and mute to a frame of PCM samples. A single time-shared multiplier processes the channels serially, and a valid/ready handshake paces frames. Optional zipper-free ramping moves each channel's gain one step at a time toward its target. It sits between the Toccata codec sample path and the audio mixer.

---
 rtl/toccata_volume_ramp.sv | 253 +++++++++++++++++++++++++
 tb/tb_toccata_volume_ramp.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/toccata_volume_ramp.sv
// toccata_volume_ramp: per-channel log attenuation and mute over a PCM frame, one shared multiplier.
// Optional zipper-free gain ramping is enabled by defining TOCCATA_VOLUME_RAMP_EN.

module toccata_volume_ramp #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int ATTEN_W  = 6,
    parameter int RAMP_DIV = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*DATA_W-1:0]  audio_in,
    input  logic [CHANNELS*ATTEN_W-1:0] attenuation,
    input  logic [CHANNELS-1:0]         mute,
    output logic [CHANNELS*DATA_W-1:0]  audio_out,
    output logic                        out_valid,
    output logic                        ramp_active
);

    localparam int LEVELS = 1 << ATTEN_W;
    localparam int GAIN_W = 17;
    localparam int IDX_W  = ATTEN_W + 1;
    localparam int CNT_W  = $clog2(CHANNELS + 2);
    localparam int PROD_W = DATA_W + GAIN_W + 1;

    // g[i] = g[i-1]*27553 >> 15 from unity; the extra top slot stays zero for silence.
    function automatic logic [(LEVELS+1)*GAIN_W-1:0] build_gain_tab();
        logic [(LEVELS+1)*GAIN_W-1:0] tab;
        logic [31:0]                  g;
        tab = {((LEVELS + 1) * GAIN_W){1'b0}};
        g   = 32'd32768;
        for (int i = 0; i < LEVELS; i++) begin
            tab[i*GAIN_W +: GAIN_W] = g[GAIN_W-1:0];
            g = (g * 32'd27553) >> 15;
        end
        return tab;
    endfunction

    localparam logic [(LEVELS+1)*GAIN_W-1:0] GAIN_TAB = build_gain_tab();

    function automatic logic [GAIN_W-1:0] gain_of(input logic [IDX_W-1:0] idx);
        logic [GAIN_W-1:0] g;
        if (idx <= IDX_W'(LEVELS)) begin
            g = GAIN_TAB[idx*GAIN_W +: GAIN_W];
        end else begin
            g = {GAIN_W{1'b0}};
        end
        return g;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [CNT_W-1:0]              cnt_r;
    logic                          accept_s;
    logic [CHANNELS*DATA_W-1:0]    frame_r;
    logic [CHANNELS*DATA_W-1:0]    shadow_r;
    logic [CHANNELS*IDX_W-1:0]     cur_att_r;
    logic [CHANNELS*IDX_W-1:0]     cur_next_s;
    logic [CHANNELS*IDX_W-1:0]     target_s;
    logic                          ramp_any_s;
    logic                          s1_valid_r;
    logic signed [DATA_W-1:0]      s1_sample_r;
    logic [GAIN_W-1:0]             s1_gain_r;
    logic [CNT_W-1:0]              s1_ch_r;
    logic signed [PROD_W-1:0]      product_s;
    logic [DATA_W-1:0]             scaled_s;
    logic                          prod_unused_s;

    // FLUSH also holds in_ready high, so a new frame may be accepted on the flush edge.
    assign accept_s = in_valid && in_ready && ((state_r == IDLE) || (state_r == FLUSH));

`ifdef TOCCATA_VOLUME_RAMP_EN
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    function automatic logic [IDX_W-1:0] step_toward(input logic [IDX_W-1:0] cur,
                                                     input logic [IDX_W-1:0] tgt);
        logic [IDX_W-1:0] nxt;
        if (cur < tgt) begin
            nxt = cur + IDX_W'(1);
        end else if (cur > tgt) begin
            nxt = cur - IDX_W'(1);
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [DIV_W-1:0] div_r;
    logic             div_wrap_s;

    assign div_wrap_s = (div_r == DIV_W'(RAMP_DIV - 1));

    // Ramp divider: counts accepted frames, wrapping every RAMP_DIV accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
        end else if (accept_s) begin
            if (div_wrap_s) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end
`else
    localparam int unused_ramp_div = RAMP_DIV;
`endif

    // Per-channel target and the gain index this accept would install.
    always_comb begin
        target_s   = {(CHANNELS * IDX_W){1'b0}};
        cur_next_s = cur_att_r;
        ramp_any_s = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mute[k]) begin
                target_s[k*IDX_W +: IDX_W] = IDX_W'(LEVELS);
            end else begin
                target_s[k*IDX_W +: IDX_W] = {1'b0, attenuation[k*ATTEN_W +: ATTEN_W]};
            end
`ifdef TOCCATA_VOLUME_RAMP_EN
            if (div_wrap_s) begin
                cur_next_s[k*IDX_W +: IDX_W] = step_toward(cur_att_r[k*IDX_W +: IDX_W],
                                                           target_s[k*IDX_W +: IDX_W]);
            end else begin
                cur_next_s[k*IDX_W +: IDX_W] = cur_att_r[k*IDX_W +: IDX_W];
            end
            ramp_any_s = ramp_any_s |
                         (cur_next_s[k*IDX_W +: IDX_W] != target_s[k*IDX_W +: IDX_W]);
`else
            cur_next_s[k*IDX_W +: IDX_W] = target_s[k*IDX_W +: IDX_W];
`endif
        end
    end

    // Frame capture, gain state and ramp flag, all updated only on an accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r     <= {(CHANNELS * DATA_W){1'b0}};
            cur_att_r   <= {CHANNELS{IDX_W'(LEVELS)}};
            ramp_active <= 1'b0;
        end else if (accept_s) begin
            frame_r     <= audio_in;
            cur_att_r   <= cur_next_s;
            ramp_active <= ramp_any_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; RUN spends one extra count so the last product reaches the shadow.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_W'(CHANNELS)) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = RUN;
                end
            end
            FLUSH: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Channel counter for the serial multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Stage 1: fetch sample and gain for the current channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_sample_r <= {DATA_W{1'b0}};
            s1_gain_r   <= {GAIN_W{1'b0}};
            s1_ch_r     <= {CNT_W{1'b0}};
        end else if ((state_r == RUN) && (cnt_r < CNT_W'(CHANNELS))) begin
            s1_valid_r  <= 1'b1;
            s1_sample_r <= frame_r[cnt_r*DATA_W +: DATA_W];
            s1_gain_r   <= gain_of(cur_att_r[cnt_r*IDX_W +: IDX_W]);
            s1_ch_r     <= cnt_r;
        end else begin
            s1_valid_r  <= 1'b0;
        end
    end

    // Floor-rounded Q15 product; unity gain never overflows DATA_W.
    assign product_s     = PROD_W'(s1_sample_r) * PROD_W'($signed({1'b0, s1_gain_r}));
    assign scaled_s      = product_s[15 +: DATA_W];
    assign prod_unused_s = ^{product_s[PROD_W-1:15+DATA_W], product_s[14:0]};

    // Stage 2: write the scaled sample into the shadow frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= {(CHANNELS * DATA_W){1'b0}};
        end else if (s1_valid_r) begin
            shadow_r[s1_ch_r*DATA_W +: DATA_W] <= scaled_s;
        end
    end

    // Registered outputs: atomic frame update, valid pulse and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            audio_out <= {(CHANNELS * DATA_W){1'b0}};
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            out_valid <= (state_r == FLUSH);
            in_ready  <= (state_next_s == IDLE) || (state_next_s == FLUSH);
            if (state_r == FLUSH) begin
                audio_out <= shadow_r;
            end
        end
    end

endmodule

// File: tb/tb_toccata_volume_ramp.sv
// Bench for toccata_volume_ramp: per-cycle comparison against a frame-level reference model,
// plus fixed vectors (ramp disabled) or ramp sequences (TOCCATA_VOLUME_RAMP_EN defined).

module tb_toccata_volume_ramp;

    localparam int C      = 4;
    localparam int DW     = 16;
    localparam int AW     = 6;
    localparam int RD     = 1;
    localparam int LEVELS = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [C*DW-1:0] audio_in;
    logic [C*AW-1:0] attenuation;
    logic [C-1:0]    mute;
    logic [C*DW-1:0] audio_out;
    logic            out_valid;
    logic            ramp_active;

    always #5 clk = ~clk;

    toccata_volume_ramp #(.CHANNELS(C), .DATA_W(DW), .ATTEN_W(AW), .RAMP_DIV(RD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .audio_in(audio_in), .attenuation(attenuation), .mute(mute),
        .audio_out(audio_out), .out_valid(out_valid), .ramp_active(ramp_active)
    );

    typedef struct {
        logic [C*DW-1:0] frame;
        int              due;
    } pend_t;

    typedef struct {
        logic [C*DW-1:0] s;
        logic [C*AW-1:0] a;
        logic [C-1:0]    m;
        logic [C*DW-1:0] e;
    } vec_t;

    int              checks = 0;
    int              errors = 0;
    int              cycle  = 0;
    int              accepts = 0;
    int              pulses  = 0;
    int              gain_lut[0:LEVELS];
    int              cur[C];
    int              divc;
    bit              exp_ready, exp_valid, exp_ramp;
    logic [C*DW-1:0] exp_out;
    pend_t           q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s, input int idx);
        longint p;
        p = longint'($signed(s)) * longint'(gain_lut[idx]);
        p = p >>> 15;
        return p[DW-1:0];
    endfunction

    task automatic model_reset();
        q.delete();
        foreach (cur[k]) cur[k] = LEVELS;
        divc      = 0;
        exp_ramp  = 1'b0;
        exp_out   = '0;
        exp_ready = 1'b0;
    endtask

    // Frame-level view: targets from the inputs, gain index moves (ramp) or jumps, then scale.
    task automatic model_accept();
        logic [C*DW-1:0] f;
        bit              any;
        bit              stepnow;
        int              tgt;
        any     = 1'b0;
        stepnow = (divc == RD - 1);
        divc    = stepnow ? 0 : divc + 1;
        for (int k = 0; k < C; k++) begin
            tgt = mute[k] ? LEVELS : int'(attenuation[k*AW +: AW]);
`ifdef TOCCATA_VOLUME_RAMP_EN
            if (stepnow && cur[k] < tgt) cur[k]++;
            else if (stepnow && cur[k] > tgt) cur[k]--;
`else
            cur[k] = tgt;
`endif
            if (cur[k] != tgt) any = 1'b1;
            f[k*DW +: DW] = scale(audio_in[k*DW +: DW], cur[k]);
        end
        exp_ramp = any;
        q.push_back('{f, cycle + 1 + C + 2});
        accepts++;
    endtask

    // One clock: update the model for this edge, then compare all outputs at the negedge.
    task automatic step();
        bit r, acc;
        r   = rst;
        acc = in_valid && exp_ready && !rst;
        if (r) model_reset();
        else if (acc) model_accept();
        @(posedge clk);
        cycle++;
        exp_valid = 1'b0;
        if (!r) begin
            if (q.size() > 0 && q[0].due == cycle) begin
                exp_out   = q[0].frame;
                exp_valid = 1'b1;
                void'(q.pop_front());
            end
            exp_ready = (q.size() == 0) || (q[0].due == cycle + 1);
        end
        @(negedge clk);
        if (out_valid) pulses++;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("audio_out", audio_out, exp_out);
        chk("ramp_active", 64'(ramp_active), 64'(exp_ramp));
    endtask

    task automatic send_frame(input logic [C*DW-1:0] s, input logic [C*AW-1:0] a,
                              input logic [C-1:0] m);
        bit will, done;
        done        = 1'b0;
        audio_in    = s;
        attenuation = a;
        mute        = m;
        in_valid    = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            will = exp_ready;
            step();
            done = will;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        in_valid    = 1'b0;
        audio_in    = {$urandom, $urandom};
        attenuation = C*AW'({$urandom, $urandom});
        mute        = C'($urandom);
    endtask

    task automatic wait_out(output logic [C*DW-1:0] got);
        bit seen;
        seen = 1'b0;
        got  = '0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            step();
            if (out_valid) begin
                seen = 1'b1;
                got  = audio_out;
                chk("latency", 64'(n), 64'(C + 2));
            end
        end
        if (!seen) chk("out_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [C*DW-1:0] got;
        logic [C-1:0]    m;
        vec_t            tv[5];
        int              p0, a0;

        gain_lut[0] = 32768;
        for (int i = 1; i < LEVELS; i++) gain_lut[i] = (gain_lut[i-1] * 27553) >>> 15;
        gain_lut[LEVELS] = 0;

        tv[0] = '{{16'h3039, 16'hFFFF, 16'h8000, 16'h7FFF}, {6'd0, 6'd1, 6'd0, 6'd1}, 4'b0000,
                  {16'h3039, 16'hFFFF, 16'h8000, 16'h6BA0}};
        tv[1] = '{{16'h3039, 16'hFED4, 16'h00C8, 16'h0064}, {6'd0, 6'd0, 6'd0, 6'd0}, 4'b1000,
                  {16'h0000, 16'hFED4, 16'h00C8, 16'h0064}};
        tv[2] = '{{16'hFFFE, 16'h0001, 16'h8000, 16'h7FFF}, {6'd1, 6'd1, 6'd2, 6'd2}, 4'b0000,
                  {16'hFFFE, 16'h0000, 16'hA581, 16'h5A7E}};
        tv[3] = '{{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001}, {6'd0, 6'd5, 6'd0, 6'd9}, 4'b1111,
                  {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        tv[4] = '{{16'h7FFF, 16'h8000, 16'h1234, 16'h0000}, {6'd0, 6'd0, 6'd0, 6'd63}, 4'b0000,
                  {16'h7FFF, 16'h8000, 16'h1234, 16'h0000}};

        rst = 1'b1; in_valid = 1'b0; audio_in = '0; attenuation = '0; mute = '0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        step();

`ifndef TOCCATA_VOLUME_RAMP_EN
        for (int i = 0; i < 5; i++) begin
            send_frame(tv[i].s, tv[i].a, tv[i].m);
            wait_out(got);
            chk($sformatf("vec%0d", i), got, tv[i].e);
        end
`else
        for (int f = 1; f <= LEVELS; f++) begin
            send_frame({C{16'd16384}}, '0, 4'b0000);
            wait_out(got);
            if (f == 1) chk("ramp_first", 64'(got[DW-1:0]), 64'(scale(16'd16384, LEVELS - 1)));
            if (f == LEVELS) chk("ramp_unity", got, {C{16'd16384}});
            chk("ramp_up_active", 64'(ramp_active), 64'(f < LEVELS));
        end
        for (int f = 1; f <= LEVELS; f++) begin
            send_frame({C{16'd16384}}, '0, 4'b1111);
            wait_out(got);
            chk("mute_ramp_ch0", 64'(got[DW-1:0]), 64'(scale(16'd16384, f)));
            chk("mute_ramp_active", 64'(ramp_active), 64'(f < LEVELS));
        end
`endif

        // Reset two clocks into a frame: the frame is dropped and the next one runs normally.
        send_frame({$urandom, $urandom}, '0, 4'b0000);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        send_frame({16'd4, 16'd3, 16'd2, 16'd1}, '0, 4'b0000);
        wait_out(got);

        // in_valid held high: back-to-back frames every C+2 clocks.
        p0 = pulses; a0 = accepts;
        in_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            audio_in    = {$urandom, $urandom};
            attenuation = C*AW'({$urandom, $urandom});
            mute        = '0;
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        chk("frames_conserved", 64'(pulses - p0), 64'(accepts - a0));
        chk("back_to_back_rate", 64'(accepts - a0), 64'(10));

        // Randomized traffic with gaps, occasional mutes and input changes mid-frame.
        for (int n = 0; n < 400; n++) begin
            audio_in = {$urandom, $urandom};
            if ($urandom_range(3) == 0) attenuation = C*AW'({$urandom, $urandom});
            for (int k = 0; k < C; k++) m[k] = ($urandom_range(7) == 0);
            mute     = m;
            in_valid = ($urandom_range(2) != 0);
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
